// File: rtl/ps2_kbd_fifo.sv
// PS/2 keyboard receiver: synchronised, majority-filtered frame decoder feeding
// an 8-deep byte FIFO whose head is presented to the cpu keyboard port.
module ps2_kbd_fifo #(
    parameter int FIFO_AW = 3,
    parameter int TIMEOUT = 2500
) (
    input  logic       clock,
    input  logic       locked,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       kb_tr,
    output logic [7:0] kb_ch,
    output logic       kb_hit,
    output logic       kb_ovf
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int TW    = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

    state_t             state_q, state_d;
    logic [1:0]         clk_sync_q, clk_sync_d;
    logic [1:0]         data_sync_q, data_sync_d;
    logic [1:0]         clk_hist_q, clk_hist_d;
    logic               clk_filt_q, clk_filt_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         shift_q, shift_d;
    logic               par_q, par_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               kb_tr_q, kb_tr_d;
    logic [7:0]         kb_ch_q, kb_ch_d;
    logic               kb_hit_q, kb_hit_d;
    logic               kb_ovf_q, kb_ovf_d;

    logic [7:0] mem [DEPTH];

    logic clk_maj, fall, data_bit, push_req, pop, full, wr_en;

    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk};
        data_sync_d = {data_sync_q[0], ps2_data};
        clk_hist_d  = {clk_hist_q[0], clk_sync_q[1]};
        clk_maj     = (clk_sync_q[1] & clk_hist_q[0]) | (clk_sync_q[1] & clk_hist_q[1]) |
                      (clk_hist_q[0] & clk_hist_q[1]);
        clk_filt_d  = clk_maj;
        fall        = clk_filt_q & ~clk_maj;
        data_bit    = data_sync_q[1];

        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tmo_d     = tmo_q;
        push_req  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                if (fall && !data_bit) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (fall) begin
                    shift_d   = {data_bit, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (fall) begin
                    par_d   = data_bit;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall) begin
                    push_req = data_bit & (^shift_q ^ par_q);
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A stalled partial frame is abandoned so the next start bit resynchronises us.
        if (state_q != ST_IDLE) begin
            if (fall) begin
                tmo_d = '0;
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                tmo_d   = '0;
                state_d = ST_IDLE;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        kb_tr_d  = kb_tr;
        pop      = kb_tr & ~kb_tr_q & (count_q != '0);
        full     = (count_q == (FIFO_AW + 1)'(DEPTH));
        wr_en    = push_req & (~full | pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        kb_ovf_d = kb_ovf_q;

        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            kb_ovf_d = 1'b0;
        end
        if (push_req && full && !pop) kb_ovf_d = 1'b1;

        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        kb_ch_d  = mem[rd_ptr_q];
        kb_hit_d = (count_q != '0);
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr_q] <= shift_q;
    end

    always_ff @(posedge clock or negedge locked) begin
        if (!locked) begin
            state_q     <= ST_IDLE;
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_hist_q  <= 2'b11;
            clk_filt_q  <= 1'b1;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            kb_tr_q     <= 1'b0;
            kb_ch_q     <= 8'h00;
            kb_hit_q    <= 1'b0;
            kb_ovf_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_hist_q  <= clk_hist_d;
            clk_filt_q  <= clk_filt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            kb_tr_q     <= kb_tr_d;
            kb_ch_q     <= kb_ch_d;
            kb_hit_q    <= kb_hit_d;
            kb_ovf_q    <= kb_ovf_d;
        end
    end

    assign kb_ch  = kb_ch_q;
    assign kb_hit = kb_hit_q;
    assign kb_ovf = kb_ovf_q;

endmodule

// File: tb/tb_ps2_kbd_fifo.sv
// Bench for ps2_kbd_fifo: PS/2 frames are bit-banged at 20 system clocks per
// half period; accepted bytes are modelled in exp_q and checked on each pop.
module tb_ps2_kbd_fifo;

    localparam int HALF = 20;

    logic       clock = 1'b0;
    logic       locked = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       kb_tr = 1'b0;
    logic [7:0] kb_ch;
    logic       kb_hit;
    logic       kb_ovf;

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_q[$];
    logic       ovf_exp = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       bad_par;
        logic       bad_stop;
        logic       accept;
    } vec_t;

    vec_t vecs[8];

    ps2_kbd_fifo #(.FIFO_AW(3), .TIMEOUT(2500)) dut (
        .clock    (clock),
        .locked   (locked),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .kb_tr    (kb_tr),
        .kb_ch    (kb_ch),
        .kb_hit   (kb_hit),
        .kb_ovf   (kb_ovf)
    );

    // 25 MHz system clock
    always #20 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Frame order on the wire: start, d[0..7], odd parity, stop.
    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic bp, input logic bs);
        return {~bs, (~^d) ^ bp, d, 1'b0};
    endfunction

    task automatic drive_bit(input logic b);
        ps2_data = b;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) drive_bit(f[i]);
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bp, input logic bs);
        send_bits(mk_frame(d, bp, bs), 11);
        tick(4);
    endtask

    task automatic expect_rx(input logic [7:0] d);
        if (exp_q.size() < 8) exp_q.push_back(d);
        else ovf_exp = 1'b1;
    endtask

    task automatic check_head(input string name);
        chk({name, "_hit"}, kb_hit, exp_q.size() != 0);
        if (exp_q.size() != 0) chk({name, "_ch"}, kb_ch, exp_q[0]);
        chk({name, "_ovf"}, kb_ovf, ovf_exp);
    endtask

    task automatic pop_check(input string name);
        chk({name, "_hit"}, kb_hit, 1);
        chk({name, "_ch"}, kb_ch, exp_q.pop_front());
        kb_tr = 1'b1;
        tick(2);
        kb_tr = 1'b0;
        tick(2);
        ovf_exp = 1'b0;
    endtask

    task automatic drain(input string name);
        while (exp_q.size() != 0) pop_check(name);
        check_head({name, "_end"});
    endtask

    initial begin
        vecs[0] = '{8'hF0, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{8'h1C, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{8'h1C, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h32, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'h77, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'h00, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{8'hFF, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{8'h80, 1'b1, 1'b0, 1'b0};

        tick(3);
        chk("rst_ch", kb_ch, 8'h00);
        chk("rst_hit", kb_hit, 0);
        chk("rst_ovf", kb_ovf, 0);
        locked = 1'b1;
        tick(3);

        // T1: stop-bit fall is driven by hand to measure latency; the first
        // clock edge that samples the low pin is edge 1, kb_hit rises on the
        // 4th clock after it.
        send_bits(mk_frame(8'h1C, 1'b0, 1'b0), 10);
        tick(HALF);
        ps2_clk = 1'b0;
        tick(4);
        chk("t1_early", kb_hit, 0);
        tick(1);
        chk("t1_lat_hit", kb_hit, 1);
        chk("t1_lat_ch", kb_ch, 8'h1C);
        tick(HALF);
        ps2_clk = 1'b1;
        tick(HALF);
        exp_q.push_back(8'h1C);
        drain("t1");

        // T2/T3 and more: table of good and corrupt frames
        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop);
            if (vecs[i].accept) expect_rx(vecs[i].data);
            check_head($sformatf("vec%0d", i));
        end
        drain("vec_drain");

        // T4: partial frame followed by a long idle must be dropped
        send_bits(mk_frame(8'hA5, 1'b0, 1'b0), 5);
        tick(2600);
        send_frame(8'h5A, 1'b0, 1'b0);
        expect_rx(8'h5A);
        check_head("t4");
        drain("t4");

        // T5: nine frames into an eight-deep FIFO
        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i), 1'b0, 1'b0);
            expect_rx(8'(i));
        end
        check_head("t5_full");
        pop_check("t5_pop");
        check_head("t5_after");
        send_frame(8'h09, 1'b0, 1'b0);
        expect_rx(8'h09);
        check_head("t5_refill");

        // T6: full FIFO, pop lands in the same cycle as the push of 0x0A
        send_bits(mk_frame(8'h0A, 1'b0, 1'b0), 10);
        tick(HALF);
        ps2_clk = 1'b0;
        tick(3);
        chk("t6_head", kb_ch, exp_q[0]);
        kb_tr = 1'b1;
        void'(exp_q.pop_front());
        exp_q.push_back(8'h0A);
        tick(2);
        kb_tr = 1'b0;
        tick(HALF);
        ps2_clk = 1'b1;
        tick(HALF);
        check_head("t6_same");
        send_frame(8'h0B, 1'b0, 1'b0);
        expect_rx(8'h0B);
        check_head("t6_still_full");
        drain("t6");

        // T7: reset in the middle of a frame
        send_frame(8'h11, 1'b0, 1'b0);
        expect_rx(8'h11);
        check_head("t7_pre");
        send_bits(mk_frame(8'h3C, 1'b0, 1'b0), 4);
        locked = 1'b0;
        #1;
        chk("t7_rst_hit", kb_hit, 0);
        chk("t7_rst_ch", kb_ch, 8'h00);
        chk("t7_rst_ovf", kb_ovf, 0);
        exp_q.delete();
        ovf_exp = 1'b0;
        tick(5);
        locked = 1'b1;
        tick(5);
        send_frame(8'h29, 1'b0, 1'b0);
        expect_rx(8'h29);
        check_head("t7_post");
        drain("t7");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
